prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//  Writer side of the instruction-memory interface: streams 9-bit machine-code words into
//  instruction memory, one word per handshake, at sequential addresses. The fetch path reads
//  the same memory by program counter.
//  Holds the core in reset while loading. Releases it only after a trailing XOR checksum word
//  matches the words received.
// PARAMETERS
//  D     12  address width; matches program counter width, memory depth 2**D
//  W     9   instruction (machine code) width
// PORTS
//  clk          in   1    system clock, rising edge
//  reset        in   1    asynchronous, active-low reset
//  start        in   1    1-cycle pulse: begin a load; sampled in IDLE, DONE, ERR only
//  len          in   D+1  number of program words to load, 1..2**D; sampled with start
//  in_valid     in   1    source has a word on in_data
//  in_data      in   W    program word, or checksum word after the last program word
//  in_ready     out  1    loader accepts in_data this cycle
//  im_wr_en     out  1    instruction memory write strobe
//  im_addr      out  D    instruction memory write address
//  im_wr_data   out  W    instruction memory write data
//  core_reset   out  1    active-high reset to PC/core; 0 only in DONE
//  busy         out  1    1 in LOAD and CHECK
//  load_done    out  1    1 in DONE (load complete, checksum good)
//  chk_err      out  1    1 in ERR (checksum mismatch)
// BEHAVIOUR
//  - Reset (async, reset==0): state IDLE, addr counter 0, word counter 0, xor accumulator 0.
//    Outputs: in_ready 0, im_wr_en 0, im_addr 0, im_wr_data 0, core_reset 1, busy 0,
//    load_done 0, chk_err 0.
//  - Handshake: a word transfers on a rising edge where in_valid && in_ready.
//    in_data must be held stable until it transfers. in_ready is a registered state decode
//    and does not depend on in_valid.
//  - States: IDLE, LOAD, CHECK, DONE, ERR.
//  - IDLE: in_ready 0, core_reset 1.
//      start && len!=0 -> LOAD; latch len; clear counter and accumulator.
//      start && len==0 -> ignored; stay in IDLE.
//  - LOAD: in_ready 1, busy 1. Each transfer:
//      registered write, im_wr_en=1 the cycle after the transfer;
//      im_addr = word count, im_wr_data = in_data;
//      acc ^= in_data; count++.
//    The transfer of word len-1 -> CHECK.
//  - CHECK: in_ready 1, busy 1, im_wr_en 0 (after the final LOAD write retires).
//      Transfer with in_data==acc -> DONE; with in_data!=acc -> ERR.
//      The checksum word is never written to memory.
//  - DONE: load_done 1, core_reset 0, in_ready 0.
//  - ERR: chk_err 1, core_reset 1, in_ready 0.
//  - start in DONE or ERR: same as in IDLE. On entering LOAD, core_reset rises, and
//    load_done/chk_err clear, in the same edge.
//  - start in LOAD or CHECK: ignored; len is not re-sampled.
//  - len == 2**D: im_addr runs 0 .. 2**D-1 with no wrap; a D+1-bit counter compares against len.
//  - im_wr_en asserts exactly once per transferred program word; at most one write per cycle.
//    Back-to-back transfers give back-to-back writes.
//  - Reset mid-load: immediate return to IDLE with reset outputs. Words already written stay in
//    memory (no clear). core_reset stays 1.
//  - Latency: start to in_ready = 1 cycle. Last program transfer to last write = 1 cycle.
//    Checksum transfer to DONE/core_reset low = 1 cycle.
// TESTING
//  1. start, len=3; words 0x1A3, 0x004, 0x0FF, checksum 0x158, all back-to-back
//     -> writes (0,0x1A3), (1,0x004), (2,0x0FF); load_done=1; core_reset=0 one cycle after
//     the checksum transfer.
//  2. Same words, checksum 0x159 -> chk_err=1, core_reset stays 1, load_done 0.
//     Then start, len=1, word 0x005, checksum 0x005 -> DONE.
//  3. len=2, in_valid toggled 1,0,0,1,1 -> exactly 2 writes, at addr 0 and 1.
//     No write in idle cycles. The third valid word is treated as the checksum.
//  4. reset asserted after 2 of 4 words -> all outputs at reset values asynchronously.
//     After release: IDLE, in_ready 0, no further writes.
//  5. start pulsed during LOAD (len=4) -> ignored; exactly 4 writes, then CHECK.
//  6. len=0 start -> stays IDLE, in_ready 0.
//     len=2**D (D=4 build, 16 words) -> last write at addr 15, then CHECK, no address wrap.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: writer side of the instruction-memory interface.
// Streams W-bit program words into instruction memory at sequential
// addresses, one per handshake, then compares a trailing XOR checksum word.
// The core is held in reset until a load completes with a good checksum.
module prog_loader #(
    parameter int D = 12,
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [D:0]   len,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         im_wr_en,
    output logic [D-1:0] im_addr,
    output logic [W-1:0] im_wr_data,
    output logic         core_reset,
    output logic         busy,
    output logic         load_done,
    output logic         chk_err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    logic [2:0]   state;
    logic [D:0]   cnt;      // D+1 bits so len == 2**D is reachable without wrap
    logic [D:0]   len_q;
    logic [W-1:0] acc;
    logic         xfer;
    logic         load_xfer;

    assign xfer      = in_valid && in_ready;
    assign load_xfer = xfer && (state == S_LOAD);

    // Status outputs are pure decodes of the registered state.
    always_comb begin
        in_ready   = (state == S_LOAD) || (state == S_CHECK);
        busy       = (state == S_LOAD) || (state == S_CHECK);
        load_done  = (state == S_DONE);
        chk_err    = (state == S_ERR);
        core_reset = (state != S_DONE);
    end

    // Sequencing: start sampling, word counting, checksum accumulation and compare.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            len_q <= '0;
            acc   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start && (len != '0)) begin
                        state <= S_LOAD;
                        len_q <= len;
                        cnt   <= '0;
                        acc   <= '0;
                    end
                end
                S_LOAD: begin
                    if (xfer) begin
                        acc <= acc ^ in_data;
                        cnt <= cnt + 1'b1;
                        if (cnt == len_q - 1'b1) begin
                            state <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (xfer) begin
                        state <= (in_data == acc) ? S_DONE : S_ERR;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Registered memory write port: one strobe the cycle after each program-word transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im_wr_en   <= 1'b0;
            im_addr    <= '0;
            im_wr_data <= '0;
        end else begin
            im_wr_en <= load_xfer;
            if (load_xfer) begin
                im_addr    <= cnt[D-1:0];
                im_wr_data <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed and randomized checks of prog_loader against a
// word-count/queue style reference model, built with D=4 so a full-depth
// load is short.
module tb_prog_loader;

    localparam int D = 4;
    localparam int W = 9;

    logic         clk      = 1'b0;
    logic         reset    = 1'b1;
    logic         start    = 1'b0;
    logic [D:0]   len      = '0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data  = '0;
    logic         in_ready;
    logic         im_wr_en;
    logic [D-1:0] im_addr;
    logic [W-1:0] im_wr_data;
    logic         core_reset;
    logic         busy;
    logic         load_done;
    logic         chk_err;

    prog_loader #(.D(D), .W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .len        (len),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .im_wr_en   (im_wr_en),
        .im_addr    (im_addr),
        .im_wr_data (im_wr_data),
        .core_reset (core_reset),
        .busy       (busy),
        .load_done  (load_done),
        .chk_err    (chk_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: a load is "words still owed" plus a running XOR;
    // once nothing is owed, the next accepted word is the checksum.
    bit           m_load = 1'b0;
    int           m_left = 0;
    int           m_len  = 0;
    int           m_res  = 0;   // 0 none, 1 checksum good, 2 checksum bad
    logic [W-1:0] m_acc  = '0;
    bit           e_wr   = 1'b0;
    logic [D-1:0] e_addr = '0;
    logic [W-1:0] e_data = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_load <= 1'b0;
            m_left <= 0;
            m_res  <= 0;
            e_wr   <= 1'b0;
        end else begin
            e_wr <= 1'b0;
            if (m_load) begin
                if (in_valid) begin
                    if (m_left > 0) begin
                        e_wr   <= 1'b1;
                        e_addr <= D'(m_len - m_left);
                        e_data <= in_data;
                        m_acc  <= m_acc ^ in_data;
                        m_left <= m_left - 1;
                    end else begin
                        m_res  <= (in_data == m_acc) ? 1 : 2;
                        m_load <= 1'b0;
                    end
                end
            end else if (start && (len != '0)) begin
                m_load <= 1'b1;
                m_len  <= int'(len);
                m_left <= int'(len);
                m_acc  <= '0;
                m_res  <= 0;
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        bit m_done;
        bit m_err;
        m_done = !m_load && (m_res == 1);
        m_err  = !m_load && (m_res == 2);
        chk("ctrl", {27'b0, in_ready, busy, load_done, chk_err, core_reset},
                    {27'b0, m_load, m_load, m_done, m_err, !m_done});
        chk("wr_en", {31'b0, im_wr_en}, {31'b0, e_wr});
        if (e_wr) begin
            chk("wr_addr", {28'b0, im_addr}, {28'b0, e_addr});
            chk("wr_data", {23'b0, im_wr_data}, {23'b0, e_data});
        end
    end

    // Log of writes seen on the memory port, for the literal checks.
    int           wr_n = 0;
    logic [D-1:0] wr_a[$];
    logic [W-1:0] wr_d[$];

    always @(negedge clk) begin
        if (im_wr_en) begin
            wr_a.push_back(im_addr);
            wr_d.push_back(im_wr_data);
            wr_n++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_start(input int l);
        start = 1'b1;
        len   = (D+1)'(l);
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic chk_wr(input string name, input int idx, input int a, input int d);
        chk({name, "_addr"}, {28'b0, wr_a[idx]}, a);
        chk({name, "_data"}, {23'b0, wr_d[idx]}, d);
    endtask

    task automatic chk_reset_outs(input string name);
        chk({name, "_in_ready"},   {31'b0, in_ready},   0);
        chk({name, "_im_wr_en"},   {31'b0, im_wr_en},   0);
        chk({name, "_im_addr"},    {28'b0, im_addr},    0);
        chk({name, "_im_wr_data"}, {23'b0, im_wr_data}, 0);
        chk({name, "_core_reset"}, {31'b0, core_reset}, 1);
        chk({name, "_busy"},       {31'b0, busy},       0);
        chk({name, "_load_done"},  {31'b0, load_done},  0);
        chk({name, "_chk_err"},    {31'b0, chk_err},    0);
    endtask

    initial begin
        int base;
        logic [W-1:0] x;
        logic [W-1:0] d;
        bit aborted;

        // Power-on reset
        #1 reset = 1'b0;
        #1 chk_reset_outs("por");
        idle(2);
        reset = 1'b1;
        idle(1);

        // len == 0 is ignored in IDLE
        do_start(0);
        chk("len0_in_ready", {31'b0, in_ready}, 0);
        chk("len0_busy", {31'b0, busy}, 0);
        idle(1);
        chk("len0_in_ready2", {31'b0, in_ready}, 0);

        // Good load of three words
        base = wr_n;
        do_start(3);
        chk("t1_in_ready", {31'b0, in_ready}, 1);
        send(9'h1A3);
        send(9'h004);
        send(9'h0FF);
        chk("t1_check_busy", {31'b0, busy}, 1);
        chk("t1_check_core_reset", {31'b0, core_reset}, 1);
        send(9'h158);
        chk("t1_load_done", {31'b0, load_done}, 1);
        chk("t1_core_reset", {31'b0, core_reset}, 0);
        chk("t1_nwr", wr_n - base, 3);
        chk_wr("t1_w0", base + 0, 0, 9'h1A3);
        chk_wr("t1_w1", base + 1, 1, 9'h004);
        chk_wr("t1_w2", base + 2, 2, 9'h0FF);

        // Bad checksum, then a one-word recovery load
        do_start(3);
        chk("t2_restart_load_done", {31'b0, load_done}, 0);
        chk("t2_restart_core_reset", {31'b0, core_reset}, 1);
        send(9'h1A3);
        send(9'h004);
        send(9'h0FF);
        send(9'h159);
        chk("t2_chk_err", {31'b0, chk_err}, 1);
        chk("t2_core_reset", {31'b0, core_reset}, 1);
        chk("t2_load_done", {31'b0, load_done}, 0);
        base = wr_n;
        do_start(1);
        chk("t2_err_cleared", {31'b0, chk_err}, 0);
        send(9'h005);
        send(9'h005);
        chk("t2b_load_done", {31'b0, load_done}, 1);
        chk("t2b_nwr", wr_n - base, 1);
        chk_wr("t2b_w0", base, 0, 9'h005);

        // Gaps in in_valid
        base = wr_n;
        do_start(2);
        send(9'h011);
        idle(2);
        send(9'h022);
        send(9'h033);
        chk("t3_nwr", wr_n - base, 2);
        chk_wr("t3_w0", base + 0, 0, 9'h011);
        chk_wr("t3_w1", base + 1, 1, 9'h022);
        chk("t3_load_done", {31'b0, load_done}, 1);

        // Reset in the middle of a load
        do_start(4);
        send(9'h101);
        send(9'h0AA);
        base = wr_n;
        reset = 1'b0;
        #1 chk_reset_outs("t4_async");
        idle(1);
        reset = 1'b1;
        in_valid = 1'b1;
        in_data  = 9'h1FF;
        idle(3);
        in_valid = 1'b0;
        chk("t4_in_ready", {31'b0, in_ready}, 0);
        chk("t4_nwr", wr_n - base, 0);

        // start during LOAD is ignored
        base = wr_n;
        do_start(4);
        send(9'h001);
        start    = 1'b1;
        len      = 5'd2;
        in_valid = 1'b1;
        in_data  = 9'h002;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        send(9'h004);
        send(9'h008);
        idle(1);
        chk("t5_nwr", wr_n - base, 4);
        chk("t5_check_busy", {31'b0, busy}, 1);
        chk("t5_check_ready", {31'b0, in_ready}, 1);
        send(9'h00F);
        chk("t5_load_done", {31'b0, load_done}, 1);

        // Full-depth load: 16 words, no address wrap
        base = wr_n;
        x = '0;
        do_start(16);
        for (int k = 0; k < 16; k++) begin
            d = W'($urandom);
            x ^= d;
            send(d);
        end
        idle(1);
        chk("t6_nwr", wr_n - base, 16);
        chk("t6_first_addr", {28'b0, wr_a[base]}, 0);
        chk("t6_last_addr", {28'b0, wr_a[base + 15]}, 15);
        chk("t6_check_busy", {31'b0, busy}, 1);
        send(x);
        chk("t6_load_done", {31'b0, load_done}, 1);

        // Randomized loads against the model
        for (int it = 0; it < 60; it++) begin
            int l;
            l = $urandom_range(0, 16);
            do_start(l);
            if (l == 0) continue;
            x = '0;
            aborted = 1'b0;
            for (int k = 0; k < l; k++) begin
                int gaps;
                gaps = $urandom_range(0, 2);
                repeat (gaps) begin
                    in_data = W'($urandom);
                    start   = ($urandom_range(0, 7) == 0);
                    len     = (D+1)'($urandom_range(0, 16));
                    tick();
                    start   = 1'b0;
                end
                d = W'($urandom);
                x ^= d;
                send(d);
                if ($urandom_range(0, 39) == 0) begin
                    reset = 1'b0;
                    tick();
                    reset = 1'b1;
                    aborted = 1'b1;
                    break;
                end
            end
            if (!aborted) begin
                if ($urandom_range(0, 3) == 0) send(x ^ W'($urandom_range(1, 511)));
                else send(x);
            end
            idle($urandom_range(0, 2));
        end

        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
